// File: rtl/slc3_run_ctrl.sv
// rtl/slc3_run_ctrl.sv - Run/Continue pushbutton sequencer for the SLC-3 CPU core
//
// Synchronizes and debounces the active-low Run and Continue buttons, runs the
// IDLE/RUN/PAUSED sequencer, and drives the CPU clock-enable, start/resume
// pulses and the latched pause-code LEDs.
//
// Optional feature macro: SLC3_SINGLE_STEP_EN (single-step execution via step_mode).
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous active-low reset
//   Run          in   raw Run pushbutton, active-low
//   Continue     in   raw Continue pushbutton, active-low
//   pause_req    in   CPU is in a PAUSE state
//   pause_code   in   [CODE_W] LED code carried by the PAUSE instruction
//   step_mode    in   single-step request (used only with SLC3_SINGLE_STEP_EN)
//   cpu_en       out  CPU state/register advance enable
//   start_pulse  out  1-cycle pulse: reset PC/ISDU and begin execution
//   resume_pulse out  1-cycle pulse: leave PAUSE state
//   paused       out  sequencer is in PAUSED
//   LED          out  [CODE_W] latched pause code

module slc3_run_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int CODE_W    = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Continue,
    input  logic              pause_req,
    input  logic [CODE_W-1:0] pause_code,
    input  logic              step_mode,
    output logic              cpu_en,
    output logic              start_pulse,
    output logic              resume_pulse,
    output logic              paused,
    output logic [CODE_W-1:0] LED
);

    localparam int                CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES);

    // Button index 0 = Run, 1 = Continue
    localparam int BTN_RUN  = 0;
    localparam int BTN_CONT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED
    } state_e;

    logic [1:0]       raw_btn;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;

    state_e            state_q, state_d;
    logic              cpu_en_q, cpu_en_d;
    logic              start_q, start_d;
    logic              resume_q, resume_d;
    logic              paused_q, paused_d;
    logic [CODE_W-1:0] led_q, led_d;
    // Set when a pause has been taken; cleared once pause_req drops, so a
    // pause_req still high after resume is not taken a second time.
    logic              pause_block_q, pause_block_d;

    logic run_press;
    logic cont_press;

    assign raw_btn = {Continue, Run};

    // Debounce: the counter tracks consecutive cycles of disagreement between
    // the synchronized level and the accepted level; the accepted level flips
    // on the cycle after the count reaches DB_CYCLES. A press is the flip to 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            press[i] = 1'b0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]  = sync2_q[i];
                    press[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign run_press  = press[BTN_RUN];
    assign cont_press = press[BTN_CONT];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Sequencer; Run always takes priority over Continue and over pause_req.
    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        resume_d      = 1'b0;
        led_d         = led_q;
        pause_block_d = pause_block_q & pause_req;

        case (state_q)
            ST_IDLE: begin
                if (run_press) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    start_d = 1'b1;
                end else if (pause_req && !pause_block_q) begin
                    state_d       = ST_PAUSED;
                    led_d         = pause_code;
                    pause_block_d = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (run_press) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end else if (cont_press) begin
                    state_d  = ST_RUN;
                    resume_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        paused_d = (state_d == ST_PAUSED);
        cpu_en_d = (state_d == ST_RUN);
`ifdef SLC3_SINGLE_STEP_EN
        // Single-step: in RUN each Continue press advances the CPU one cycle.
        if ((state_d == ST_RUN) && step_mode) begin
            cpu_en_d = (state_q == ST_RUN) && cont_press && !run_press;
        end
`endif
    end

`ifndef SLC3_SINGLE_STEP_EN
    logic unused_step_mode;
    assign unused_step_mode = step_mode;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            cpu_en_q      <= 1'b0;
            start_q       <= 1'b0;
            resume_q      <= 1'b0;
            paused_q      <= 1'b0;
            led_q         <= '0;
            pause_block_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_en_q      <= cpu_en_d;
            start_q       <= start_d;
            resume_q      <= resume_d;
            paused_q      <= paused_d;
            led_q         <= led_d;
            pause_block_q <= pause_block_d;
        end
    end

    assign cpu_en       = cpu_en_q;
    assign start_pulse  = start_q;
    assign resume_pulse = resume_q;
    assign paused       = paused_q;
    assign LED          = led_q;

endmodule

// File: tb/tb_slc3_run_ctrl.sv
// tb/tb_slc3_run_ctrl.sv - self-checking bench for slc3_run_ctrl

module tb_slc3_run_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_n;
    logic       cont_n;
    logic       preq;
    logic [9:0] pcode;
    logic       smode;

    logic       cpu_en;
    logic       start_pulse;
    logic       resume_pulse;
    logic       paused;
    logic [9:0] led;

    int checks = 0;
    int errors = 0;

    slc3_run_ctrl #(
        .DB_CYCLES (DB),
        .CODE_W    (10)
    ) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .Run          (run_n),
        .Continue     (cont_n),
        .pause_req    (preq),
        .pause_code   (pcode),
        .step_mode    (smode),
        .cpu_en       (cpu_en),
        .start_pulse  (start_pulse),
        .resume_pulse (resume_pulse),
        .paused       (paused),
        .LED          (led)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history per button; an accepted level flips
    // when the synchronized samples (raw delayed two cycles) have disagreed
    // with it for DB+1 consecutive cycles.
    bit       hist_run[$];
    bit       hist_cont[$];
    bit       m_db_run, m_db_cont;
    int       m_state;   // 0 idle, 1 run, 2 paused
    bit       m_armed;
    bit [9:0] m_led;
    bit       m_cpu_en, m_start, m_resume, m_paused;

    function automatic bit all_differ(input bit h[$], input bit lvl);
        for (int j = h.size() - 3 - DB; j <= h.size() - 3; j++)
            if (h[j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_run.delete();
        hist_cont.delete();
        for (int j = 0; j < DB + 3; j++) begin
            hist_run.push_back(1'b1);
            hist_cont.push_back(1'b1);
        end
        m_db_run = 1; m_db_cont = 1;
        m_state = 0; m_armed = 1; m_led = '0;
        m_cpu_en = 0; m_start = 0; m_resume = 0; m_paused = 0;
    endtask

    task automatic model_step();
        bit run_ev, cont_ev, captured;
        int prev;
        hist_run.push_back(run_n);
        hist_cont.push_back(cont_n);
        if (hist_run.size() > 40) void'(hist_run.pop_front());
        if (hist_cont.size() > 40) void'(hist_cont.pop_front());
        run_ev = 0; cont_ev = 0;
        if (all_differ(hist_run, m_db_run)) begin
            m_db_run = ~m_db_run;
            run_ev = (m_db_run == 1'b0);
        end
        if (all_differ(hist_cont, m_db_cont)) begin
            m_db_cont = ~m_db_cont;
            cont_ev = (m_db_cont == 1'b0);
        end
        prev = m_state;
        m_start = 0; m_resume = 0; captured = 0;
        if (run_ev) begin
            m_state = 1; m_start = 1;
        end else if (prev == 1 && preq && m_armed) begin
            m_state = 2; m_led = pcode; captured = 1;
        end else if (prev == 2 && cont_ev) begin
            m_state = 1; m_resume = 1;
        end
        m_armed = captured ? 1'b0 : (m_armed | !preq);
        m_paused = (m_state == 2);
        m_cpu_en = (m_state == 1);
`ifdef SLC3_SINGLE_STEP_EN
        if (m_state == 1 && smode)
            m_cpu_en = (prev == 1) && cont_ev && !run_ev;
`endif
    endtask

    // Advance one clock; inputs change only at the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; run_n = 1; cont_n = 1; preq = 0; pcode = '0; smode = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (led !== 10'h000) begin errors++; $display("FAIL reset_led got=%h exp=000", led); end
        checks++; if (start_pulse !== 1'b0 || resume_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", start_pulse, resume_pulse); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got=%b exp=0", paused); end
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int i = 0; i < 14; i++) begin
            run_n = (i < 2) ? 1'b0 : 1'b1;
            tick();
            if (start_pulse !== 1'b0 || cpu_en !== 1'b0 || m_start) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_no_start got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_run_start();
        int pulses = 0;
        int at = -1;
        for (int i = 1; i <= 16; i++) begin
            run_n = (i <= 8) ? 1'b0 : 1'b1;
            tick();
            if (start_pulse === 1'b1) begin pulses++; if (at < 0) at = i; end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL run_start_count got=%0d exp=1", pulses); end
        checks++; if (at != 2 + DB + 1) begin errors++; $display("FAIL run_start_latency got=%0d exp=%0d", at, 2 + DB + 1); end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_cpu_en got=%b exp=1", cpu_en); end
    endtask

    task automatic test_pause_continue();
        int res = 0, st = 0;
        preq = 1; pcode = 10'h007;
        tick();
        preq = 0; pcode = 10'h3FF;
        checks++; if (paused !== 1'b1 || cpu_en !== 1'b0) begin errors++; $display("FAIL pause_enter got paused=%b cpu_en=%b exp paused=1 cpu_en=0", paused, cpu_en); end
        checks++; if (led !== 10'h007) begin errors++; $display("FAIL pause_led got=%h exp=007", led); end
        for (int i = 1; i <= 16; i++) begin
            cont_n = (i <= 8) ? 1'b0 : 1'b1;
            tick();
            if (resume_pulse === 1'b1) res++;
            if (start_pulse === 1'b1) st++;
        end
        checks++; if (res != 1 || st != 0) begin errors++; $display("FAIL continue_pulses got resume=%0d start=%0d exp resume=1 start=0", res, st); end
        checks++; if (cpu_en !== 1'b1 || paused !== 1'b0) begin errors++; $display("FAIL continue_run got cpu_en=%b paused=%b exp 1 0", cpu_en, paused); end
        checks++; if (led !== 10'h007) begin errors++; $display("FAIL continue_led got=%h exp=007", led); end
    endtask

    task automatic test_simultaneous();
        int res = 0, st = 0;
        preq = 1; pcode = 10'h12A;
        tick();
        preq = 0;
        checks++; if (paused !== 1'b1 || led !== 10'h12A) begin errors++; $display("FAIL simul_pause got paused=%b led=%h exp 1 12a", paused, led); end
        for (int i = 1; i <= 16; i++) begin
            run_n  = (i <= 8) ? 1'b0 : 1'b1;
            cont_n = (i <= 8) ? 1'b0 : 1'b1;
            tick();
            if (resume_pulse === 1'b1) res++;
            if (start_pulse === 1'b1) st++;
        end
        checks++; if (st != 1 || res != 0) begin errors++; $display("FAIL simul_pulses got start=%0d resume=%0d exp start=1 resume=0", st, res); end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL simul_cpu_en got=%b exp=1", cpu_en); end
    endtask

`ifdef SLC3_SINGLE_STEP_EN
    task automatic test_single_step();
        int en_cycles = 0, longest = 0, run_len = 0;
        smode = 1;
        for (int i = 0; i < 60; i++) begin
            cont_n = ((i % 20) < 8) ? 1'b0 : 1'b1;
            tick();
            if (cpu_en === 1'b1) begin en_cycles++; run_len++; if (run_len > longest) longest = run_len; end
            else run_len = 0;
        end
        checks++; if (en_cycles != 3 || longest != 1) begin errors++; $display("FAIL single_step got en=%0d longest=%0d exp 3 1", en_cycles, longest); end
        smode = 0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        int bad = 0;
        run_n = 0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 0;
        #1;
        checks++; if (cpu_en !== 1'b0 || paused !== 1'b0 || led !== 10'h000 || start_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cpu_en=%b paused=%b led=%h start=%b exp 0 0 000 0", cpu_en, paused, led, start_pulse); end
        run_n = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (start_pulse !== 1'b0 || cpu_en !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_release_event got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_random();
        int hold_r = 10, hold_c = 10, hold_p = 3, hold_s = 20;
        int bad_cpu = 0, bad_st = 0, bad_rs = 0, bad_pa = 0, bad_led = 0, bad_excl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (--hold_r <= 0) begin
                run_n = ~run_n;
                hold_r = run_n ? $urandom_range(60, 10) : $urandom_range(9, 1);
            end
            if (--hold_c <= 0) begin
                cont_n = ~cont_n;
                hold_c = cont_n ? $urandom_range(25, 3) : $urandom_range(9, 1);
            end
            if (--hold_p <= 0) begin
                preq = ~preq;
                pcode = 10'($urandom);
                hold_p = $urandom_range(12, 1);
            end
            if (--hold_s <= 0) begin
                smode = ~smode;
                hold_s = $urandom_range(200, 20);
            end
            tick();
            if (cpu_en !== m_cpu_en) begin bad_cpu++; if (bad_cpu < 4) $display("FAIL rand_cpu_en cyc=%0d got=%b exp=%b", i, cpu_en, m_cpu_en); end
            if (start_pulse !== m_start) begin bad_st++; if (bad_st < 4) $display("FAIL rand_start cyc=%0d got=%b exp=%b", i, start_pulse, m_start); end
            if (resume_pulse !== m_resume) begin bad_rs++; if (bad_rs < 4) $display("FAIL rand_resume cyc=%0d got=%b exp=%b", i, resume_pulse, m_resume); end
            if (paused !== m_paused) begin bad_pa++; if (bad_pa < 4) $display("FAIL rand_paused cyc=%0d got=%b exp=%b", i, paused, m_paused); end
            if (led !== m_led) begin bad_led++; if (bad_led < 4) $display("FAIL rand_led cyc=%0d got=%h exp=%h", i, led, m_led); end
            if (start_pulse === 1'b1 && resume_pulse === 1'b1) begin bad_excl++; if (bad_excl < 4) $display("FAIL rand_exclusive cyc=%0d got=11 exp=not both", i); end
        end
        checks += 6;
        if (bad_cpu != 0) errors++;
        if (bad_st != 0) errors++;
        if (bad_rs != 0) errors++;
        if (bad_pa != 0) errors++;
        if (bad_led != 0) errors++;
        if (bad_excl != 0) errors++;
        run_n = 1; cont_n = 1; preq = 0; smode = 0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_run_start();
        test_pause_continue();
        test_simultaneous();
`ifdef SLC3_SINGLE_STEP_EN
        test_single_step();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
